alu_control_unit: RTL and testbench

Registered ALU control decoder for the MIPS datapath. It maps the main-decoder ALUOp code and, for R-type instructions, the instruction funct field to a 4-bit ALU operation select. The output is registered, so it is valid one cycle after its inputs, and it feeds the ALU operation select.

---
 rtl/alu_control_unit.sv | 100 ++++++++++
 tb/tb_alu_control_unit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/alu_control_unit.sv
// ---------------------------------------------------------------------------
// alu_control_unit
//
// Registered ALU control decoder for the MIPS datapath. Combines the main
// decoder's ALUOp class with, for R-type instructions, the funct field to
// produce the 4-bit ALU operation select. Both outputs are registered, so
// they reflect the inputs sampled at the previous rising clock edge.
//
// Ports:
//   clk      - system clock, all state updates on the rising edge
//   rst_n    - synchronous active-low reset
//   ALUOp    - operation class from the main control unit [2:0]
//   func     - instruction funct field [5:0]
//   ALUCtl   - registered ALU operation select [3:0]
//   illegal  - registered flag, high for unsupported ALUOp/func combinations
// ---------------------------------------------------------------------------
module alu_control_unit #(
  parameter logic [3:0] RESET_CTL = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] ALUOp,
  input  logic [5:0] func,
  output logic [3:0] ALUCtl,
  output logic       illegal
);

  // ALU operation encodings
  localparam logic [3:0] CTL_AND  = 4'b0000;
  localparam logic [3:0] CTL_OR   = 4'b0001;
  localparam logic [3:0] CTL_ADD  = 4'b0010;
  localparam logic [3:0] CTL_XOR  = 4'b0011;
  localparam logic [3:0] CTL_SUB  = 4'b0110;
  localparam logic [3:0] CTL_SLT  = 4'b0111;
  localparam logic [3:0] CTL_SLL  = 4'b1000;
  localparam logic [3:0] CTL_SRL  = 4'b1001;
  localparam logic [3:0] CTL_SRA  = 4'b1010;
  localparam logic [3:0] CTL_SLTU = 4'b1011;
  localparam logic [3:0] CTL_NOR  = 4'b1100;
  localparam logic [3:0] CTL_LUI  = 4'b1101;
  localparam logic [3:0] CTL_INV  = 4'b1111;

  // ALUOp class that defers to the funct field
  localparam logic [2:0] OP_RTYPE = 3'b010;

  logic [3:0] next_ctl;
  logic       next_illegal;

  // Next-state decode. Only the R-type class looks at func; every other
  // class is a fixed operation and can never be illegal.
  always_comb begin
    next_ctl     = CTL_INV;
    next_illegal = 1'b0;
    unique case (ALUOp)
      3'b000: next_ctl = CTL_ADD;
      3'b001: next_ctl = CTL_SUB;
      3'b011: next_ctl = CTL_OR;
      3'b100: next_ctl = CTL_AND;
      3'b101: next_ctl = CTL_SLT;
      3'b110: next_ctl = CTL_LUI;
      3'b111: next_ctl = CTL_XOR;
      OP_RTYPE: begin
        case (func)
          6'b100000, 6'b100001: next_ctl = CTL_ADD;   // add, addu
          6'b100010, 6'b100011: next_ctl = CTL_SUB;   // sub, subu
          6'b100100:            next_ctl = CTL_AND;
          6'b100101:            next_ctl = CTL_OR;
          6'b100110:            next_ctl = CTL_XOR;
          6'b100111:            next_ctl = CTL_NOR;
          6'b101010:            next_ctl = CTL_SLT;
          6'b101011:            next_ctl = CTL_SLTU;
          6'b000000, 6'b000100: next_ctl = CTL_SLL;   // sll, sllv
          6'b000010, 6'b000110: next_ctl = CTL_SRL;   // srl, srlv
          6'b000011, 6'b000111: next_ctl = CTL_SRA;   // sra, srav
          6'b001000:            next_ctl = CTL_ADD;   // jr: pass-through add
          default: begin
            next_ctl     = CTL_INV;
            next_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        next_ctl     = CTL_INV;
        next_illegal = 1'b0;
      end
    endcase
  end

  // Output registers; reset takes priority over the decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ALUCtl  <= RESET_CTL;
      illegal <= 1'b0;
    end else begin
      ALUCtl  <= next_ctl;
      illegal <= next_illegal;
    end
  end

endmodule

// File: tb/tb_alu_control_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_control_unit
//
// Directed testbench for alu_control_unit. Inputs change on the falling
// edge; outputs are sampled 1 time unit after the rising edge. Expected
// values are hand-computed from the ALU control encoding table.
// ---------------------------------------------------------------------------
module tb_alu_control_unit;

  logic       clk;
  logic       rst_n;
  logic [2:0] ALUOp;
  logic [5:0] func;
  logic [3:0] ALUCtl;
  logic       illegal;

  int checks = 0;
  int errors = 0;

  alu_control_unit #(.RESET_CTL(4'b0000)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ALUOp   (ALUOp),
    .func    (func),
    .ALUCtl  (ALUCtl),
    .illegal (illegal)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare both outputs against expected values.
  task automatic check(input string tag, input logic [3:0] exp_ctl,
                       input logic exp_ill);
    checks++;
    assert (ALUCtl === exp_ctl) else begin
      errors++;
      $error("FAIL %s ALUCtl observed=%b expected=%b", tag, ALUCtl, exp_ctl);
    end
    checks++;
    assert (illegal === exp_ill) else begin
      errors++;
      $error("FAIL %s illegal observed=%b expected=%b", tag, illegal, exp_ill);
    end
  endtask

  // Apply inputs at the falling edge, then sample just after the rising edge.
  task automatic step(input logic [2:0] op, input logic [5:0] f);
    @(negedge clk);
    ALUOp = op;
    func  = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    ALUOp = 3'b010;
    func  = 6'b100010;

    // 1. Reset held for two edges
    @(posedge clk); #1;
    check("reset_edge1", 4'b0000, 1'b0);
    @(posedge clk); #1;
    check("reset_edge2", 4'b0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ALUOp = 3'b000;
    func  = 6'b111111;
    #1;
    check("release_no_change", 4'b0000, 1'b0);
    @(posedge clk); #1;
    check("first_decode", 4'b0010, 1'b0);

    // 2. R-type and vs. andi
    step(3'b010, 6'b100100); check("rtype_and", 4'b0000, 1'b0);
    step(3'b100, 6'b100100); check("andi",      4'b0000, 1'b0);

    // 3. R-type funct sweep
    step(3'b010, 6'b100000); check("add",  4'b0010, 1'b0);
    step(3'b010, 6'b100001); check("addu", 4'b0010, 1'b0);
    step(3'b010, 6'b100010); check("sub",  4'b0110, 1'b0);
    step(3'b010, 6'b100011); check("subu", 4'b0110, 1'b0);
    step(3'b010, 6'b100101); check("or",   4'b0001, 1'b0);
    step(3'b010, 6'b100110); check("xor",  4'b0011, 1'b0);
    step(3'b010, 6'b100111); check("nor",  4'b1100, 1'b0);
    step(3'b010, 6'b101010); check("slt",  4'b0111, 1'b0);
    step(3'b010, 6'b101011); check("sltu", 4'b1011, 1'b0);
    step(3'b010, 6'b000000); check("sll",  4'b1000, 1'b0);
    step(3'b010, 6'b000010); check("srl",  4'b1001, 1'b0);
    step(3'b010, 6'b000011); check("sra",  4'b1010, 1'b0);
    step(3'b010, 6'b000100); check("sllv", 4'b1000, 1'b0);
    step(3'b010, 6'b000110); check("srlv", 4'b1001, 1'b0);
    step(3'b010, 6'b000111); check("srav", 4'b1010, 1'b0);
    step(3'b010, 6'b001000); check("jr",   4'b0010, 1'b0);

    // 4. Non-R-type classes ignore func
    step(3'b000, 6'b111111); check("op000", 4'b0010, 1'b0);
    step(3'b001, 6'b111111); check("op001", 4'b0110, 1'b0);
    step(3'b011, 6'b111111); check("op011", 4'b0001, 1'b0);
    step(3'b100, 6'b111111); check("op100", 4'b0000, 1'b0);
    step(3'b101, 6'b111111); check("op101", 4'b0111, 1'b0);
    step(3'b110, 6'b111111); check("op110", 4'b1101, 1'b0);
    step(3'b111, 6'b111111); check("op111", 4'b0011, 1'b0);

    // 5. Unsupported funct, then recovery
    step(3'b010, 6'b111111); check("illegal_ff",  4'b1111, 1'b1);
    step(3'b010, 6'b001001); check("illegal_09",  4'b1111, 1'b1);
    step(3'b010, 6'b000001); check("illegal_01",  4'b1111, 1'b1);
    step(3'b000, 6'b111111); check("recover_add", 4'b0010, 1'b0);

    // 6a. Inputs change between edges: outputs hold until the rising edge
    step(3'b010, 6'b100111); check("pre_latency", 4'b1100, 1'b0);
    @(negedge clk);
    ALUOp = 3'b010;
    func  = 6'b111110;
    #2;
    check("hold_between_edges", 4'b1100, 1'b0);
    @(posedge clk); #1;
    check("after_edge", 4'b1111, 1'b1);

    // 6b. Reset mid-operation overrides decode
    @(negedge clk);
    rst_n = 1'b0;
    ALUOp = 3'b010;
    func  = 6'b100010;
    @(posedge clk); #1;
    check("mid_reset", 4'b0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_sub", 4'b0110, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
